// File: rtl/mmc1_serial_writer.sv
// Generates NES CPU write cycles that load an MMC1 serially: five D0 writes (LSB first),
// or a single D7=1 write that resets the mapper's shift register.
module mmc1_serial_writer #(
  parameter int HALF = 3,
  parameter int GAP  = 1
) (
  input  logic       CLK,
  input  logic       nRES,
  input  logic       REQ,
  input  logic       RST_CMD,
  input  logic [1:0] REG,
  input  logic [4:0] VAL,
  output logic       BUSY,
  output logic       DONE,
  output logic       M2,
  output logic       nROMSEL,
  output logic       CPU_RnW,
  output logic       CPU_A14,
  output logic       CPU_A13,
  output logic       CPU_D0,
  output logic       CPU_D7
);
  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(HALF - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WRITE, S_GAPW, S_FIN} state_t;

  state_t        state;
  logic [PW-1:0] ph;
  logic [GW-1:0] gcnt;
  logic [2:0]    k;
  logic [1:0]    reg_q;
  logic [4:0]    val_q;
  logic          rst_q;
  logic          bnd_q;

  logic ph_wrap, m2_rise, m2_fall;
  assign ph_wrap = (ph == PH_LAST);
  assign m2_rise = ph_wrap && !M2;
  assign m2_fall = ph_wrap && M2;   // CPU cycle boundary

  always_ff @(posedge CLK) begin
    if (!nRES) begin
      state   <= S_IDLE;
      ph      <= '0;
      M2      <= 1'b0;
      nROMSEL <= 1'b1;
      CPU_RnW <= 1'b1;
      CPU_A14 <= 1'b0;
      CPU_A13 <= 1'b0;
      CPU_D0  <= 1'b0;
      CPU_D7  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      k       <= '0;
      gcnt    <= '0;
      reg_q   <= '0;
      val_q   <= '0;
      rst_q   <= 1'b0;
      bnd_q   <= 1'b0;
    end else begin
      ph    <= ph_wrap ? '0 : ph + 1'b1;
      bnd_q <= m2_fall;
      DONE  <= 1'b0;
      if (ph_wrap) M2 <= !M2;

      if (m2_rise)      nROMSEL <= (state != S_WRITE);
      else if (m2_fall) nROMSEL <= 1'b1;

      // Bus fields move one CLK after the boundary so they hold past the M2 fall.
      if (bnd_q) begin
        CPU_RnW <= (state != S_WRITE);
        if (state == S_WRITE) begin
          {CPU_A14, CPU_A13} <= reg_q;
          CPU_D0             <= rst_q ? 1'b0 : val_q[k];
          CPU_D7             <= rst_q;
        end
      end

      case (state)
        S_IDLE, S_FIN: begin
          state <= S_IDLE;
          if (REQ) begin
            reg_q <= REG;
            val_q <= VAL;
            rst_q <= RST_CMD;
            BUSY  <= 1'b1;
            state <= S_ARM;
          end
        end
        S_ARM: begin
          if (m2_fall) state <= S_WRITE;
        end
        S_WRITE: begin
          if (m2_fall) begin
            state <= S_GAPW;
            gcnt  <= GAP_LAST;
          end
        end
        S_GAPW: begin
          if (m2_fall) begin
            if (gcnt != '0) begin
              gcnt <= gcnt - 1'b1;
            end else if (rst_q || k == 3'd4) begin
              state <= S_FIN;
              k     <= '0;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end else begin
              k     <= k + 1'b1;
              state <= S_WRITE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
